cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_tb_pkg.sv | 18 +
 rtl/sat_counter.sv | 28 ++
 rtl/cpu_run_ctrl.sv | 147 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_tb_pkg.sv
// Shared state encoding and default parameters for the CPU run controller.
package cpu_tb_pkg;

    localparam int DEF_PC_W        = 32;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_RST_CYCLES  = 2;
    localparam int DEF_STALL_LIMIT = 3;
    localparam int DEF_TIMEOUT     = 10000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CORE_RST = 3'd1,
        ST_RUN      = 3'd2,
        ST_HALTED   = 3'd3,
        ST_ABORT    = 3'd4
    } run_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter
    import cpu_tb_pkg::*;
#(
    parameter int WIDTH = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: resets the core, lets it run until a halt PC, a PC stall or a
// cycle timeout, and keeps cycle/retire statistics for the run.
module cpu_run_ctrl
    import cpu_tb_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_pc_valid,
    input  logic [PC_W-1:0]  i_halt_addr,
    output logic             o_core_rst,
    output logic             o_running,
    output logic             o_done,
    output logic             o_timed_out,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic [CNT_W-1:0] o_retire_count
);

    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SL_W  = $clog2(STALL_LIMIT + 1);
    localparam int CMP_W = (CNT_W > 32) ? CNT_W : 32;

    run_state_t        r_state;
    logic [RC_W-1:0]   r_rst_cnt;
    logic [PC_W-1:0]   r_halt_addr;
    logic [PC_W-1:0]   r_last_pc;
    logic [SL_W-1:0]   r_same;
    logic              r_core_rst;
    logic              r_running;
    logic              r_done;
    logic              r_timed_out;

    logic              w_in_run;
    logic              w_begin;
    logic [SL_W:0]     w_run_len;
    logic              w_stall;
    logic              w_match;
    logic              w_halt;
    logic              w_timeout;
    logic [CNT_W-1:0]  w_cycle_count;
    logic [CNT_W-1:0]  w_retire_count;

    assign w_in_run = (r_state == ST_RUN);
    assign w_begin  = i_start && ((r_state == ST_IDLE) || (r_state == ST_HALTED) ||
                                  (r_state == ST_ABORT));

    // Length of the current run of identical valid PCs, including this cycle.
    assign w_run_len = ((i_pc == r_last_pc) && (r_same != '0)) ? {1'b0, r_same} + 1'b1
                                                                : (SL_W + 1)'(1);
    assign w_stall   = i_pc_valid && (w_run_len >= (SL_W + 1)'(STALL_LIMIT));
    assign w_match   = i_pc_valid && (i_pc == r_halt_addr);
    assign w_halt    = w_in_run && (w_match || w_stall);
    // Fires on the RUN cycle whose increment brings cycle_count up to TIMEOUT.
    assign w_timeout = w_in_run && (CMP_W'(w_cycle_count) == CMP_W'(TIMEOUT - 1));

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_begin),
        .i_inc   (w_in_run),
        .o_count (w_cycle_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_retire_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_begin),
        .i_inc   (w_in_run && i_pc_valid),
        .o_count (w_retire_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_rst_cnt   <= '0;
            r_halt_addr <= '0;
            r_last_pc   <= '0;
            r_same      <= '0;
            r_core_rst  <= 1'b1;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALTED, ST_ABORT: begin
                    if (i_start) begin
                        r_state     <= ST_CORE_RST;
                        r_rst_cnt   <= '0;
                        r_halt_addr <= i_halt_addr;
                        r_last_pc   <= '0;
                        r_same      <= '0;
                        r_done      <= 1'b0;
                        r_timed_out <= 1'b0;
                    end
                end
                ST_CORE_RST: begin
                    if (r_rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        r_state    <= ST_RUN;
                        r_core_rst <= 1'b0;
                        r_running  <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Invalid cycles leave the stall tracker untouched.
                    if (i_pc_valid) begin
                        r_last_pc <= i_pc;
                        r_same    <= (w_run_len > (SL_W + 1)'(STALL_LIMIT)) ? SL_W'(STALL_LIMIT)
                                                                             : w_run_len[SL_W-1:0];
                    end
                    if (w_halt) begin
                        r_state    <= ST_HALTED;
                        r_done     <= 1'b1;
                        r_core_rst <= 1'b1;
                        r_running  <= 1'b0;
                    end else if (w_timeout) begin
                        r_state     <= ST_ABORT;
                        r_timed_out <= 1'b1;
                        r_core_rst  <= 1'b1;
                        r_running   <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_core_rst <= 1'b1;
                    r_running  <= 1'b0;
                end
            endcase
        end
    end

    assign o_core_rst     = r_core_rst;
    assign o_running      = r_running;
    assign o_done         = r_done;
    assign o_timed_out    = r_timed_out;
    assign o_cycle_count  = w_cycle_count;
    assign o_retire_count = w_retire_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: each run's outcome is predicted from the
// stimulus arrays at start time and checked when the DUT reports done/timed_out.
module tb_cpu_run_ctrl;

    localparam int PC_W        = 32;
    localparam int CNT_W       = 32;
    localparam int RST_CYCLES  = 2;
    localparam int STALL_LIMIT = 3;
    localparam int TIMEOUT     = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [PC_W-1:0]   pc = '0;
    logic              pc_valid = 1'b0;
    logic [PC_W-1:0]   halt_addr = '0;
    logic              core_rst, running, done, timed_out;
    logic [CNT_W-1:0]  cycle_count, retire_count;

    cpu_run_ctrl #(
        .PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES),
        .STALL_LIMIT(STALL_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pc(pc),
        .i_pc_valid(pc_valid), .i_halt_addr(halt_addr),
        .o_core_rst(core_rst), .o_running(running), .o_done(done),
        .o_timed_out(timed_out), .o_cycle_count(cycle_count),
        .o_retire_count(retire_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        done;
        logic        tout;
        logic [31:0] cyc;
        logic [31:0] ret;
        int unsigned rise;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] stim_pc [TIMEOUT];
    logic        stim_v  [TIMEOUT];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: scan the run cycle by cycle and apply the halt/stall/timeout rules.
    function automatic exp_t model(input logic [31:0] ha, input int unsigned rise, output int last);
        exp_t        e;
        logic [31:0] hist[$];
        bit          stall;
        e.done = 1'b0; e.tout = 1'b0; e.cyc = '0; e.ret = '0; e.rise = rise;
        for (int j = 0; j < TIMEOUT; j++) begin
            stall = 1'b0;
            if (stim_v[j]) begin
                e.ret = e.ret + 1;
                hist.push_back(stim_pc[j]);
                if (hist.size() >= STALL_LIMIT) begin
                    stall = 1'b1;
                    for (int k = 1; k <= STALL_LIMIT; k++)
                        if (hist[hist.size() - k] != stim_pc[j]) stall = 1'b0;
                end
                if ((stim_pc[j] == ha) || stall) begin
                    e.done = 1'b1;
                    e.cyc  = 32'(j + 1);
                    last   = j;
                    return e;
                end
            end
        end
        e.tout = 1'b1;
        e.cyc  = 32'(TIMEOUT);
        last   = TIMEOUT - 1;
        return e;
    endfunction

    // Monitor: run start and run end events pop/peek the scoreboard.
    logic prev_run = 1'b0, prev_end = 1'b0, prev_crst = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_run = 1'b0; prev_end = 1'b0; prev_crst = 1'b1;
        end else begin
            if (running && !prev_run) begin
                if (sb.size() == 0) chk("unexpected_run", 64'(running), 64'(0));
                else begin
                    chk("run_start_cycle", 64'(cyc), 64'(sb[0].rise));
                    chk("core_rst_in_run", 64'(core_rst), 64'(0));
                    chk("core_rst_before_run", 64'(prev_crst), 64'(1));
                end
            end
            if ((done || timed_out) && !prev_end) begin
                if (sb.size() == 0) chk("unexpected_end", 64'(done | timed_out), 64'(0));
                else begin
                    e = sb.pop_front();
                    chk("done", 64'(done), 64'(e.done));
                    chk("timed_out", 64'(timed_out), 64'(e.tout));
                    chk("cycle_count", 64'(cycle_count), 64'(e.cyc));
                    chk("retire_count", 64'(retire_count), 64'(e.ret));
                    chk("core_rst_after", 64'(core_rst), 64'(1));
                    chk("running_after", 64'(running), 64'(0));
                end
            end else if (sb.size() == 0) begin
                chk("idle_running", 64'(running), 64'(0));
                chk("idle_core_rst", 64'(core_rst), 64'(1));
            end
            prev_run  = running;
            prev_end  = done | timed_out;
            prev_crst = core_rst;
        end
    end

    // Reset cancels any outstanding run and must clear outputs without a clock.
    always @(negedge rst_n) begin
        sb.delete();
        #1;
        chk("rst_core_rst", 64'(core_rst), 64'(1));
        chk("rst_running", 64'(running), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_timed_out", 64'(timed_out), 64'(0));
        chk("rst_cycle_count", 64'(cycle_count), 64'(0));
        chk("rst_retire_count", 64'(retire_count), 64'(0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_run(input logic [31:0] ha, input int extra_start, input int rst_at);
        exp_t e;
        int   last;
        e = model(ha, cyc + 1 + RST_CYCLES, last);
        sb.push_back(e);
        halt_addr = ha; start = 1'b1; pc_valid = 1'b0;
        tick();
        for (int i = 0; i < RST_CYCLES; i++) begin
            start = ($urandom_range(0, 2) == 0);
            halt_addr = $urandom;
            pc = $urandom; pc_valid = $urandom_range(0, 1) == 1;
            tick();
        end
        for (int j = 0; j <= last; j++) begin
            pc = stim_pc[j]; pc_valid = stim_v[j];
            start = (j == extra_start) || ($urandom_range(0, 7) == 0);
            if (j == rst_at) begin
                #2 rst_n = 1'b0;
                start = 1'b0; pc_valid = 1'b0;
                @(posedge clk); @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (4) tick();
                return;
            end
            tick();
        end
        start = 1'b0; pc = $urandom; pc_valid = 1'b1;
        repeat (2) tick();
        pc_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev, ha;
        #2 rst_n = 1'b0;
        #20;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) tick();

        for (int j = 0; j < TIMEOUT; j++) begin stim_pc[j] = 32'(4 * j); stim_v[j] = 1'b1; end
        do_run(32'h0000_0040, 5, -1);

        for (int j = 0; j < TIMEOUT; j++) begin stim_pc[j] = 32'h10; stim_v[j] = 1'b1; end
        do_run(32'hFFFF_FFF0, -1, -1);

        for (int j = 0; j < TIMEOUT; j++) begin stim_pc[j] = 32'(32'h100 + 4 * j); stim_v[j] = 1'b1; end
        do_run(32'hDEAD_BEEF, 3, -1);

        for (int j = 0; j < TIMEOUT; j++) begin stim_pc[j] = 32'(32'h200 + 4 * j); stim_v[j] = 1'b1; end
        do_run(32'(32'h200 + 4 * (TIMEOUT - 1)), -1, -1);

        for (int j = 0; j < TIMEOUT; j++) begin stim_pc[j] = (j % 2 == 0) ? 32'h10 : 32'h99; stim_v[j] = (j % 2 == 0); end
        do_run(32'hDEAD_BEEF, -1, -1);

        for (int j = 0; j < TIMEOUT; j++) begin stim_pc[j] = 32'h0; stim_v[j] = 1'b1; end
        do_run(32'hDEAD_BEEF, -1, -1);

        for (int j = 0; j < TIMEOUT; j++) begin stim_pc[j] = 32'(32'h300 + 4 * j); stim_v[j] = 1'b1; end
        do_run(32'hDEAD_BEEF, 2, 7);

        for (int r = 0; r < 40; r++) begin
            ha   = ($urandom_range(0, 2) == 0) ? 32'(32'h10 + 4 * $urandom_range(0, 3)) : 32'hCAFE_0000;
            prev = 32'h10;
            for (int j = 0; j < TIMEOUT; j++) begin
                stim_v[j]  = ($urandom_range(0, 9) < 7);
                stim_pc[j] = ($urandom_range(0, 1) == 1) ? prev : 32'(32'h10 + 4 * $urandom_range(0, 3));
                if (stim_v[j]) prev = stim_pc[j];
            end
            do_run(ha, -1, -1);
        end

        repeat (4) tick();
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
